ysyx_bus_arbiter: RTL

//  Shares the single core memory port between the IFU L1I refill engine and the LSU.
//  - IFU issues reads only, including the two-beat line refill. ifu_required_o stays high for the whole refill.
//  - LSU issues single reads and writes.
//  - LSU has priority, with a starvation guard for IFU. A granted IFU refill is never split.

---
 rtl/ysyx_bus_arbiter_pkg.sv | 27 ++
 rtl/ysyx_bus_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_bus_arbiter_pkg.sv
// Shared types and helpers for the IFU/LSU memory-port arbiter.
package ysyx_bus_arbiter_pkg;

    // Width of the byte-strobe bus on both the LSU and memory sides.
    localparam int unsigned STRB_W = 4;

    // Fixed 3-bit encodings so state values read the same in every waveform.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIfuReq  = 3'd1,
        StIfuRsp  = 3'd2,
        StIfuHold = 3'd3,
        StLsuReq  = 3'd4,
        StLsuRsp  = 3'd5
    } arb_state_e;

    // True while the IFU owns the bus; IFU waiting cycles are not counted then.
    function automatic logic is_ifu_state(input arb_state_e st);
        return (st == StIfuReq) || (st == StIfuRsp) || (st == StIfuHold);
    endfunction

    // True while a request is presented on the memory side.
    function automatic logic is_req_state(input arb_state_e st);
        return (st == StIfuReq) || (st == StLsuReq);
    endfunction

endpackage

// File: rtl/ysyx_bus_arbiter.sv
// Arbiter sharing the single core memory port between the IFU refill engine and the LSU.
// LSU has priority; a saturating counter of IFU waiting cycles lets the IFU win once it
// has waited STARVE_MAX cycles. An IFU refill holds the bus across both beats.
module ysyx_bus_arbiter
    import ysyx_bus_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    // IFU read port
    input  logic [DATA_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    input  logic              ifu_required,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_rvalid_o,
    // LSU port
    input  logic [DATA_W-1:0] lsu_addr,
    input  logic              lsu_valid,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_rvalid_o,
    // Memory side
    output logic [DATA_W-1:0] m_addr_o,
    output logic              m_wen_o,
    output logic [DATA_W-1:0] m_wdata_o,
    output logic [STRB_W-1:0] m_wstrb_o,
    output logic              m_valid_o,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              last_ifu_q, last_ifu_d;

    logic starve_full;
    logic lsu_wins;
    logic ifu_wins;
    logic ifu_grant;

    // Arbitration decision, only acted on in StIdle.
    always_comb begin
        starve_full = (starve_cnt_q == CNT_MAX);
        lsu_wins    = lsu_valid && !(ifu_arvalid && starve_full);
        ifu_wins    = !lsu_wins && ifu_arvalid;
    end

    // Next-state logic and request latching.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        last_ifu_d = last_ifu_q;
        ifu_grant  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (lsu_wins) begin
                    addr_d     = lsu_addr;
                    wen_d      = lsu_wen;
                    wdata_d    = lsu_wdata;
                    wstrb_d    = lsu_wstrb;
                    last_ifu_d = 1'b0;
                    state_d    = StLsuReq;
                end else if (ifu_wins) begin
                    addr_d     = ifu_araddr;
                    wen_d      = 1'b0;
                    wdata_d    = '0;
                    wstrb_d    = '0;
                    last_ifu_d = 1'b1;
                    ifu_grant  = 1'b1;
                    state_d    = StIfuReq;
                end
            end
            StIfuReq: begin
                if (m_ready) begin
                    state_d = StIfuRsp;
                end
            end
            StIfuRsp: begin
                if (m_rvalid) begin
                    state_d = ifu_required ? StIfuHold : StIdle;
                end
            end
            StIfuHold: begin
                // The bus stays with the IFU between refill beats; lsu_valid is not looked at.
                if (ifu_arvalid) begin
                    addr_d    = ifu_araddr;
                    ifu_grant = 1'b1;
                    state_d   = StIfuReq;
                end else if (!ifu_required) begin
                    state_d = StIdle;
                end
            end
            StLsuReq: begin
                if (m_ready) begin
                    state_d = StLsuRsp;
                end
            end
            StLsuRsp: begin
                if (m_rvalid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Starvation counter: counts IFU waiting cycles outside IFU ownership, saturating.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ifu_grant) begin
            starve_cnt_d = '0;
        end else if (ifu_arvalid && !is_ifu_state(state_q) && !starve_full) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Memory-side request and response routing; everything is held at zero during reset.
    always_comb begin
        m_valid_o    = !rst && is_req_state(state_q);
        m_addr_o     = m_valid_o ? addr_q  : '0;
        m_wen_o      = m_valid_o && wen_q;
        m_wdata_o    = m_valid_o ? wdata_q : '0;
        m_wstrb_o    = m_valid_o ? wstrb_q : '0;

        ifu_rvalid_o = !rst && (state_q == StIfuRsp) && last_ifu_q && m_rvalid;
        lsu_rvalid_o = !rst && (state_q == StLsuRsp) && !last_ifu_q && m_rvalid;
        ifu_rdata_o  = ifu_rvalid_o ? m_rdata : '0;
        lsu_rdata_o  = lsu_rvalid_o ? m_rdata : '0;
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            starve_cnt_q <= '0;
            last_ifu_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            starve_cnt_q <= starve_cnt_d;
            last_ifu_q   <= last_ifu_d;
        end
    end

endmodule
